// File: rtl/crypto_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_isa_pkg
// Description : Instruction-set constants for the mini crypto processor:
//               opcode values, field-width defaults and the packed record of
//               decode flags that travels with each buffered instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_isa_pkg;

    // Opcode values
    localparam int OP_NOP    = 0;
    localparam int OP_ADD    = 1;
    localparam int OP_XORENC = 6;
    localparam int OP_JMP    = 7;

    // Highest legal opcode; anything above it is trapped by execute
    localparam int OPC_MAX_DEF = 7;

    // Field-width defaults
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W_DEF   = 4;
    localparam int REG_W_DEF   = 4;
    localparam int DEPTH_DEF   = 2;
    localparam int CNT_W_DEF   = 8;

    // Classification flags stored alongside the raw instruction word
    typedef struct packed {
        logic illegal;
        logic is_jump;
        logic is_crypto;
    } dec_flags_t;

    localparam int FLAGS_W = $bits(dec_flags_t);

endpackage
`default_nettype wire

// File: rtl/decode_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decode_fifo
// Description : Generic synchronous FIFO with synchronous flush and
//               asynchronous active-low reset. Read data is the current head
//               (show-ahead). Pointers wrap modulo DEPTH, so DEPTH need not be
//               a power of two.
// Ports       : clk, rst_n        - clock / async active-low reset
//               flush             - discard all entries on the next edge
//               push, wdata       - write request (ignored when full)
//               pop               - remove head (ignored when empty)
//               rdata             - head entry
//               full, empty, count- occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module decode_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Explicit wrap keeps non-power-of-two depths correct
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Pipelined instruction decode. Accepted words are classified
//               (illegal / jump / crypto) on entry and buffered, together with
//               their flags, in a small FIFO in front of execute. A saturating
//               counter tracks accepted illegal instructions.
// Ports       : clk, rst_n            - clock / async active-low reset
//               in_valid/in_ready     - fetch-side handshake
//               in_instr              - [opcode | reg1 | reg2 | imm]
//               flush                 - drop all buffered entries
//               out_valid/out_ready   - execute-side handshake
//               out_opcode/reg1/reg2/imm, out_illegal/is_jump/is_crypto
//                                     - head entry, zero when out_valid = 0
//               illegal_count         - saturating illegal-accept count
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import crypto_isa_pkg::*;
#(
    parameter  int INSTR_W = INSTR_W_DEF,
    parameter  int OPC_W   = OPC_W_DEF,
    parameter  int REG_W   = REG_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int OPC_MAX = OPC_MAX_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int IMM_W   = INSTR_W - OPC_W - 2 * REG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_reg1,
    output logic [REG_W-1:0]   out_reg2,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_illegal,
    output logic               out_is_jump,
    output logic               out_is_crypto,
    output logic [CNT_W-1:0]   illegal_count
);

    localparam int ENTRY_W = INSTR_W + FLAGS_W;
    localparam int FCNT_W  = $clog2(DEPTH + 1);

    localparam logic [OPC_W-1:0] C_OPC_MAX = OPC_W'(OPC_MAX);
    localparam logic [OPC_W-1:0] C_OP_JMP  = OPC_W'(OP_JMP);
    localparam logic [OPC_W-1:0] C_OP_XENC = OPC_W'(OP_XORENC);

    logic [OPC_W-1:0]   w_in_opcode;
    dec_flags_t         w_in_flags;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FCNT_W-1:0]  w_fcount;
    logic [ENTRY_W-1:0] w_head;
    dec_flags_t         w_head_flags;
    logic [INSTR_W-1:0] w_head_instr;
    logic [CNT_W-1:0]   r_illegal_count;

    // Classify on entry; the flags are stored so the head is never re-decoded
    assign w_in_opcode          = in_instr[INSTR_W-1 -: OPC_W];
    assign w_in_flags.illegal   = (w_in_opcode > C_OPC_MAX);
    assign w_in_flags.is_jump   = (w_in_opcode == C_OP_JMP);
    assign w_in_flags.is_crypto = (w_in_opcode == C_OP_XENC);

    // Full and count describe the same condition; both gate acceptance so the
    // handshake reads directly as "room left in the buffer"
    assign in_ready  = !w_full && (w_fcount < FCNT_W'(DEPTH));
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    decode_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .wdata ({w_in_flags, in_instr}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fcount)
    );

    assign {w_head_flags, w_head_instr} = w_head;

    // Head fields are forced to zero whenever no entry is presented
    always_comb begin
        out_opcode    = '0;
        out_reg1      = '0;
        out_reg2      = '0;
        out_imm       = '0;
        out_illegal   = 1'b0;
        out_is_jump   = 1'b0;
        out_is_crypto = 1'b0;
        if (out_valid) begin
            out_opcode    = w_head_instr[INSTR_W-1 -: OPC_W];
            out_reg1      = w_head_instr[INSTR_W-OPC_W-1 -: REG_W];
            out_reg2      = w_head_instr[IMM_W+REG_W-1 -: REG_W];
            out_imm       = w_head_instr[IMM_W-1:0];
            out_illegal   = w_head_flags.illegal;
            out_is_jump   = w_head_flags.is_jump;
            out_is_crypto = w_head_flags.is_crypto;
        end
    end

    // Counts every accepted illegal word, including one dropped by a
    // same-cycle flush; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_count <= '0;
        end else if (w_push && w_in_flags.illegal &&
                     (r_illegal_count != {CNT_W{1'b1}})) begin
            r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire
